seg_scan_driver: RTL and testbench

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

---
 rtl/seg_disp_pkg.sv | 17 +
 rtl/hex_to_seg.sv | 11 +
 rtl/seg_scan_driver.sv | 128 ++++++++++++
 tb/tb_seg_scan_driver.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_disp_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan driver.
// Glyph table is indexed by nibble value; bit 0 = segment a, bit 6 = segment g.
package seg_disp_pkg;

    typedef enum logic {
        S_BLANK = 1'b0,
        S_ON    = 1'b1
    } scan_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [15:0][6:0] GLYPH_TBL = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to 7-segment glyph decode.
module hex_to_seg
    import seg_disp_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    assign seg_o = GLYPH_TBL[nib_i];

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed 7-segment scanner with blank dead time between digits,
// frame-synchronous value update and optional leading-zero blanking.
module seg_scan_driver
    import seg_disp_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 50000,
    parameter int unsigned ON_TICKS = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] value,
    input  logic        lz_blank,
    output logic [6:0]  seg,
    output logic [3:0]  dig_en,
    output logic        frame_done
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int TW = $clog2(ON_TICKS + 1);
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
    localparam logic [TW-1:0] ON_LAST   = TW'(ON_TICKS - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [TW-1:0] ticks_q, ticks_d;
    logic [1:0]    dig_q, dig_d;
    scan_state_t   state_q, state_d;
    logic [15:0]   shadow_q, shadow_d;
    logic [15:0]   active_q, active_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    dig_en_q, dig_en_d;
    logic          fd_q;

    logic       tick;
    logic       frame_wrap;
    logic [3:0] nib;
    logic       lz_zero;
    logic [6:0] glyph;

    assign tick       = en && (presc_q == PRESC_MAX);
    assign frame_wrap = tick && (state_q == S_ON) && (ticks_q == ON_LAST) && (dig_q == 2'd3);

    assign presc_d  = !en ? presc_q : (presc_q == PRESC_MAX) ? '0 : presc_q + PW'(1);
    assign shadow_d = load ? value : shadow_q;
    // Old shadow wins on a simultaneous load, so a frame never mixes values.
    assign active_d = frame_wrap ? shadow_q : active_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q  <= '0;
            ticks_q  <= '0;
            dig_q    <= '0;
            state_q  <= S_BLANK;
            shadow_q <= '0;
            active_q <= '0;
            seg_q    <= SEG_BLANK;
            dig_en_q <= '0;
            fd_q     <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            ticks_q  <= ticks_d;
            dig_q    <= dig_d;
            state_q  <= state_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            seg_q    <= seg_d;
            dig_en_q <= dig_en_d;
            fd_q     <= frame_wrap;
        end
    end

    always_comb begin
        state_d = state_q;
        ticks_d = ticks_q;
        dig_d   = dig_q;
        if (tick) begin
            case (state_q)
                S_BLANK: begin
                    state_d = S_ON;
                    ticks_d = '0;
                end
                S_ON: begin
                    if (ticks_q == ON_LAST) begin
                        state_d = S_BLANK;
                        ticks_d = '0;
                        dig_d   = dig_q + 2'd1;
                    end else begin
                        ticks_d = ticks_q + TW'(1);
                    end
                end
                default: state_d = S_BLANK;
            endcase
        end
    end

    // Outputs are decoded from next-state values so the registered pins line up with the FSM.
    always_comb begin
        nib     = active_d[3:0];
        lz_zero = 1'b0;
        case (dig_d)
            2'd0: begin nib = active_d[3:0];   lz_zero = 1'b0;                     end
            2'd1: begin nib = active_d[7:4];   lz_zero = (active_d[15:4]  == '0);  end
            2'd2: begin nib = active_d[11:8];  lz_zero = (active_d[15:8]  == '0);  end
            2'd3: begin nib = active_d[15:12]; lz_zero = (active_d[15:12] == '0);  end
            default: begin nib = active_d[3:0]; lz_zero = 1'b0;                    end
        endcase
    end

    hex_to_seg u_hex_to_seg (
        .nib_i (nib),
        .seg_o (glyph)
    );

    always_comb begin
        seg_d    = SEG_BLANK;
        dig_en_d = '0;
        if (en && (state_d == S_ON)) begin
            dig_en_d = 4'(1) << dig_d;
            seg_d    = (lz_blank && lz_zero) ? SEG_BLANK : glyph;
        end
    end

    assign seg        = seg_q;
    assign dig_en     = dig_en_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with CLK_DIV=4, ON_TICKS=3 (16-clk slot, 64-clk frame).
module tb_seg_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic        lz_blank = 1'b0;
    logic [6:0]  seg;
    logic [3:0]  dig_en;
    logic        frame_done;

    int checks = 0;
    int errors = 0;
    int k = 0;

    seg_scan_driver #(.CLK_DIV(4), .ON_TICKS(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load       (load),
        .value      (value),
        .lz_blank   (lz_blank),
        .seg        (seg),
        .dig_en     (dig_en),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            k++;
        end
        #1;
    endtask

    task automatic step_to(input int t);
        if (t > k) step(t - k);
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (seg !== 7'h00 || dig_en !== 4'b0000 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: seg=%h dig_en=%b fd=%b, want 00 0000 0", seg, dig_en, frame_done);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        k = 0;
        step_to(3);
        checks++;
        if (dig_en !== 4'b0000 || seg !== 7'h00) begin
            errors++;
            $display("FAIL reset_blank: seg=%h dig_en=%b, want 00 0000", seg, dig_en);
        end
        step_to(4);
        checks++;
        if (dig_en !== 4'b0001 || seg !== 7'h3F) begin
            errors++;
            $display("FAIL reset_first_lit: seg=%h dig_en=%b, want 3F 0001", seg, dig_en);
        end
    endtask

    task automatic test_scan_1234();
        logic [6:0] g [4] = '{7'h66, 7'h4F, 7'h5B, 7'h06};
        logic [3:0] e_dig;
        logic [6:0] e_seg;
        load = 1'b1; value = 16'h1234;
        step(1);
        load = 1'b0;
        step_to(64);
        for (int p = 0; p < 64; p++) begin
            e_dig = (p % 16 >= 4) ? 4'(1 << (p / 16)) : 4'b0000;
            e_seg = (p % 16 >= 4) ? g[p / 16] : 7'h00;
            checks++;
            if (dig_en !== e_dig || seg !== e_seg || frame_done !== (p == 0)) begin
                errors++;
                $display("FAIL scan_1234 p=%0d: seg=%h dig_en=%b fd=%b, want %h %b %b",
                         p, seg, dig_en, frame_done, e_seg, e_dig, (p == 0));
            end
            step(1);
        end
    endtask

    task automatic test_lz_blank();
        logic [6:0] g [4] = '{7'h3F, 7'h77, 7'h00, 7'h00};
        logic [3:0] e_dig;
        logic [6:0] e_seg;
        lz_blank = 1'b1;
        load = 1'b1; value = 16'h00A0;
        step(1);
        load = 1'b0;
        step_to(192);
        for (int p = 0; p < 64; p++) begin
            e_dig = (p % 16 >= 4) ? 4'(1 << (p / 16)) : 4'b0000;
            e_seg = (p % 16 >= 4) ? g[p / 16] : 7'h00;
            checks++;
            if (dig_en !== e_dig || seg !== e_seg || frame_done !== (p == 0)) begin
                errors++;
                $display("FAIL lz_blank p=%0d: seg=%h dig_en=%b fd=%b, want %h %b %b",
                         p, seg, dig_en, frame_done, e_seg, e_dig, (p == 0));
            end
            step(1);
        end
    endtask

    task automatic test_overwrite();
        logic [3:0] e_dig;
        logic [6:0] e_seg;
        step_to(260);
        load = 1'b1; value = 16'hAAAA;
        step(1);
        load = 1'b0;
        step_to(290);
        load = 1'b1; value = 16'h5555;
        step(1);
        load = 1'b0;
        step_to(320);
        for (int p = 0; p < 64; p++) begin
            e_dig = (p % 16 >= 4) ? 4'(1 << (p / 16)) : 4'b0000;
            e_seg = (p % 16 >= 4) ? 7'h6D : 7'h00;
            checks++;
            if (dig_en !== e_dig || seg !== e_seg || frame_done !== (p == 0)) begin
                errors++;
                $display("FAIL overwrite p=%0d: seg=%h dig_en=%b fd=%b, want %h %b %b",
                         p, seg, dig_en, frame_done, e_seg, e_dig, (p == 0));
            end
            // load lands on the same edge as the frame boundary
            if (p == 63) begin load = 1'b1; value = 16'h8888; end
            step(1);
        end
        load = 1'b0;
        step_to(388);
        checks++;
        if (dig_en !== 4'b0001 || seg !== 7'h6D) begin
            errors++;
            $display("FAIL load_at_boundary: seg=%h dig_en=%b, want 6D 0001", seg, dig_en);
        end
    endtask

    task automatic test_en_pause();
        step_to(424);
        checks++;
        if (dig_en !== 4'b0100 || seg !== 7'h6D) begin
            errors++;
            $display("FAIL pause_before: seg=%h dig_en=%b, want 6D 0100", seg, dig_en);
        end
        en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            checks++;
            if (dig_en !== 4'b0000 || seg !== 7'h00 || frame_done !== 1'b0) begin
                errors++;
                $display("FAIL pause_off i=%0d: seg=%h dig_en=%b fd=%b, want 00 0000 0",
                         i, seg, dig_en, frame_done);
            end
        end
        en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step(1);
            checks++;
            if (dig_en !== 4'b0100 || seg !== 7'h6D) begin
                errors++;
                $display("FAIL pause_resume i=%0d: seg=%h dig_en=%b, want 6D 0100", i, seg, dig_en);
            end
        end
        step(1);
        checks++;
        if (dig_en !== 4'b0000) begin
            errors++;
            $display("FAIL pause_slot_end: dig_en=%b, want 0000", dig_en);
        end
        step_to(456);
        checks++;
        if (dig_en !== 4'b1000 || seg !== 7'h6D) begin
            errors++;
            $display("FAIL pause_next_digit: seg=%h dig_en=%b, want 6D 1000", seg, dig_en);
        end
        step_to(531);
        checks++;
        if (frame_done !== 1'b0) begin
            errors++;
            $display("FAIL pause_fd_early: fd=%b, want 0", frame_done);
        end
        step(1);
        checks++;
        if (frame_done !== 1'b1 || dig_en !== 4'b0000) begin
            errors++;
            $display("FAIL pause_fd: fd=%b dig_en=%b, want 1 0000", frame_done, dig_en);
        end
        step_to(536);
        checks++;
        if (dig_en !== 4'b0001 || seg !== 7'h7F) begin
            errors++;
            $display("FAIL next_frame_8888: seg=%h dig_en=%b, want 7F 0001", seg, dig_en);
        end
    endtask

    task automatic test_reset_midframe();
        load = 1'b1; value = 16'hFFFF;
        step(1);
        load = 1'b0;
        step_to(560);
        checks++;
        if (dig_en !== 4'b0010 || seg !== 7'h7F) begin
            errors++;
            $display("FAIL pre_reset: seg=%h dig_en=%b, want 7F 0010", seg, dig_en);
        end
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (seg !== 7'h00 || dig_en !== 4'b0000 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: seg=%h dig_en=%b fd=%b, want 00 0000 0", seg, dig_en, frame_done);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        k = 0;
        for (int i = 1; i <= 64; i++) begin
            step(1);
            checks++;
            if (frame_done !== (k == 64)) begin
                errors++;
                $display("FAIL post_reset_fd k=%0d: fd=%b, want %b", k, frame_done, (k == 64));
            end
            if (k == 4) begin
                checks++;
                if (dig_en !== 4'b0001 || seg !== 7'h3F) begin
                    errors++;
                    $display("FAIL post_reset_d0: seg=%h dig_en=%b, want 3F 0001", seg, dig_en);
                end
            end
            if (k == 20) begin
                checks++;
                if (dig_en !== 4'b0010 || seg !== 7'h00) begin
                    errors++;
                    $display("FAIL post_reset_d1: seg=%h dig_en=%b, want 00 0010", seg, dig_en);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan_1234();
        test_lz_blank();
        test_overwrite();
        test_en_pause();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
